// File: rtl/cadu_serializer.sv
// rtl/cadu_serializer.sv - CADU frame to serial bit stream, MSB first, CLK_DIV cycles per bit
// Optional CCSDS pseudo-randomizer enabled by defining CADU_RANDOMIZER_EN.
module cadu_serializer #(
  parameter int CADU_WIDTH = 2,
  parameter int CLK_DIV    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CADU_WIDTH*8-1:0] frame_i,
  input  logic                    frame_valid_i,
  output logic                    frame_ready_o,
  output logic                    data_o,
  output logic                    data_valid_o,
  output logic                    serializer_done_o,
  output logic [1:0]              fsm_state_o
);

  localparam int NBITS = CADU_WIDTH * 8;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  logic [1:0]       state;
  logic [NBITS-1:0] shreg;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             tick;
  logic             tx_bit;

  assign tick = (div_cnt == DIV_LAST);

`ifdef CADU_RANDOMIZER_EN
  // lfsr[7] is the current PN bit; the feedback realises x^8+x^7+x^5+x^3+1
  logic [7:0] lfsr;
  assign tx_bit = shreg[NBITS-1] ^ lfsr[7];
`else
  assign tx_bit = shreg[NBITS-1];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
`ifdef CADU_RANDOMIZER_EN
      lfsr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (frame_valid_i) begin
            shreg   <= frame_i;
            div_cnt <= '0;
            bit_cnt <= '0;
`ifdef CADU_RANDOMIZER_EN
            lfsr    <= 8'hFF;
`endif
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            div_cnt <= '0;
            shreg   <= {shreg[NBITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + BIT_W'(1);
`ifdef CADU_RANDOMIZER_EN
            lfsr    <= {lfsr[6:0], lfsr[0] ^ lfsr[2] ^ lfsr[4] ^ lfsr[7]};
`endif
            if (bit_cnt == BIT_LAST) begin
              state <= DONE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        DONE: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    frame_ready_o     = (state == IDLE);
    data_valid_o      = (state == SHIFT);
    serializer_done_o = (state == DONE);
    data_o            = (state == SHIFT) & tx_bit;
    fsm_state_o       = state;
  end

endmodule

// File: tb/tb_cadu_serializer.sv
// tb/tb_cadu_serializer.sv - directed and random self-checking bench for cadu_serializer
module tb_cadu_serializer;

  localparam int NB = 16;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [NB-1:0] frame_i = '0;
  logic          frame_valid_i = 1'b0;
  logic          frame_ready_o;
  logic          data_o;
  logic          data_valid_o;
  logic          serializer_done_o;
  logic [1:0]    fsm_state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  cadu_serializer #(.CADU_WIDTH(NB/8), .CLK_DIV(CD)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .frame_i           (frame_i),
    .frame_valid_i     (frame_valid_i),
    .frame_ready_o     (frame_ready_o),
    .data_o            (data_o),
    .data_valid_o      (data_valid_o),
    .serializer_done_o (serializer_done_o),
    .fsm_state_o       (fsm_state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected serial word: the frame, optionally XORed with the PN sequence
  // a[k] = a[k-1]^a[k-3]^a[k-5]^a[k-8] starting from eight ones.
  function automatic logic [NB-1:0] model(input logic [NB-1:0] f);
    logic a [0:NB+7];
    logic [NB-1:0] pn;
    pn = '0;
`ifdef CADU_RANDOMIZER_EN
    for (int k = 0; k < NB; k++) begin
      a[k] = (k < 8) ? 1'b1 : (a[k-1] ^ a[k-3] ^ a[k-5] ^ a[k-8]);
      pn[NB-1-k] = a[k];
    end
`else
    a[0] = 1'b0;
`endif
    return f ^ pn;
  endfunction

  task automatic send(input logic [NB-1:0] f, input bit keep, input int pulse_at,
                      input int rst_at, input string tag);
    logic [NB-1:0] rx;
    bit ok;
    int w;
    w = 0;
    while (frame_ready_o !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready_before"}, frame_ready_o, 1);
    frame_i = f;
    frame_valid_i = 1'b1;
    @(negedge clk);
    if (!keep) frame_valid_i = 1'b0;
    frame_i = NB'($urandom);
    rx = '0;
    ok = 1'b1;
    for (int i = 0; i < NB*CD; i++) begin
      if (i == rst_at) begin
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check({tag, " rst_valid"}, data_valid_o, 0);
        check({tag, " rst_data"}, data_o, 0);
        check({tag, " rst_done"}, serializer_done_o, 0);
        check({tag, " rst_ready"}, frame_ready_o, 1);
        check({tag, " rst_state"}, fsm_state_o, 0);
        return;
      end
      if (i == pulse_at) begin
        frame_i = '1;
        frame_valid_i = 1'b1;
      end else if (i == pulse_at + 1 && !keep) begin
        frame_valid_i = 1'b0;
      end
      if (data_valid_o !== 1'b1 || serializer_done_o !== 1'b0 ||
          frame_ready_o !== 1'b0 || fsm_state_o !== 2'b01) ok = 1'b0;
      if (i % CD == 0) rx[NB-1-i/CD] = data_o;
      else if (data_o !== rx[NB-1-i/CD]) ok = 1'b0;
      @(negedge clk);
    end
    check({tag, " data"}, rx, model(f));
    check({tag, " shift_hold"}, ok, 1);
    check({tag, " done_pulse"}, serializer_done_o, 1);
    check({tag, " done_valid"}, data_valid_o, 0);
    check({tag, " done_data"}, data_o, 0);
    check({tag, " done_ready"}, frame_ready_o, 0);
    check({tag, " done_state"}, fsm_state_o, 2);
    @(negedge clk);
    check({tag, " ready_after"}, frame_ready_o, 1);
    check({tag, " gap_valid"}, data_valid_o, 0);
    check({tag, " post_done"}, serializer_done_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset data", data_o, 0);
    check("reset valid", data_valid_o, 0);
    check("reset done", serializer_done_o, 0);
    check("reset ready", frame_ready_o, 1);
    check("reset state", fsm_state_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    send(16'h4F00, 1'b0, -1, -1, "single");
    repeat (2) @(negedge clk);

    send(16'h4F00, 1'b0, 3*CD, -1, "busy");
    quiet = 1'b1;
    repeat (6) begin
      if (data_valid_o !== 1'b0 || serializer_done_o !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    check("busy no_second_frame", quiet, 1);

    send(16'hA5C3, 1'b1, -1, -1, "b2b_first");
    send(16'h3C5A, 1'b0, -1, -1, "b2b_second");
    @(negedge clk);

    send(16'h4F00, 1'b0, -1, 5*CD + 1, "midrst");
    quiet = 1'b1;
    repeat (NB*CD + 4) begin
      if (data_valid_o !== 1'b0 || serializer_done_o !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    check("midrst no_done", quiet, 1);
    send(16'h00FF, 1'b0, -1, -1, "after_rst");

    send(16'h0000, 1'b0, -1, -1, "zero");

    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(NB'($urandom), 1'b0, -1, -1, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cadu_serializer.md
CADU_SERIALIZER -- requirements
Module: cadu_serializer

Interface
REQ-001 Parameter CADU_WIDTH, default 2, number of CADU bytes per frame.
REQ-002 Parameter CLK_DIV, default 4, clock cycles per output bit; legal range 1..255.
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 frame_i  input  CADU_WIDTH*8  frame from the CCSDS tx framer; byte 0 in the MSBs.
REQ-006 frame_valid_i  input  1  frame_i holds a frame to send.
REQ-007 frame_ready_o  output  1  block can accept a frame.
REQ-008 data_o  output  1  serial bit stream, MSB first.
REQ-009 data_valid_o  output  1  data_o carries a frame bit.
REQ-010 serializer_done_o  output  1  one-cycle pulse when a frame has been fully shifted out; drives the framer's serializer_done_i.
REQ-011 fsm_state_o  output  2  current state encoding, for debug.

Function
REQ-012 The FSM SHALL have three states: IDLE=2'b00, SHIFT=2'b01 and DONE=2'b10. Encoding 2'b11 is unreachable and SHALL return to IDLE.
REQ-013 IDLE: frame_ready_o=1. On frame_valid_i&&frame_ready_o, the block SHALL capture frame_i into the shift register, clear the bit and divider counters, and go to SHIFT.
REQ-014 SHIFT: frame_ready_o=0 and data_valid_o=1. data_o SHALL equal the current MSB of the shift register.
REQ-015 The divider SHALL count 0..CLK_DIV-1. At CLK_DIV-1 the block SHALL shift left by one and increment the bit counter.
REQ-016 Each bit SHALL be held for exactly CLK_DIV cycles. data_valid_o SHALL be high for exactly CADU_WIDTH*8*CLK_DIV consecutive cycles, starting the cycle after the handshake.
REQ-017 After the last divider tick of bit CADU_WIDTH*8-1, the FSM SHALL go to DONE. DONE lasts one cycle, with serializer_done_o=1, data_valid_o=0 and frame_ready_o=0, then returns to IDLE.
REQ-018 Latency from the handshake cycle to the serializer_done_o pulse SHALL be CADU_WIDTH*8*CLK_DIV+1 cycles. frame_ready_o SHALL reassert the cycle after the pulse.
REQ-019 frame_valid_i while frame_ready_o=0 SHALL be ignored. The captured frame SHALL be unaffected by later changes on frame_i.
REQ-020 If frame_valid_i is held high continuously, the next frame SHALL be captured in the first IDLE cycle, giving a 2-cycle data_valid_o gap between frames.
REQ-021 data_o SHALL be 0 whenever data_valid_o=0.
REQ-022 CLK_DIV=1 SHALL produce one bit per cycle with no idle cycles inside a frame.
REQ-023 Counter widths SHALL be $clog2 sized and SHALL NOT overflow for CADU_WIDTH up to 1115 bytes.

Reset
REQ-024 While rst_i=1 at a clock edge, the block SHALL set: state=IDLE, data_o=0, data_valid_o=0, serializer_done_o=0, frame_ready_o=1 (from the next cycle), and shift register, counters and LFSR cleared.
REQ-025 Reset during SHIFT or DONE SHALL abort the frame with no done pulse. The next accepted frame SHALL restart from its MSB.

Configuration
REQ-026 Macro CADU_RANDOMIZER_EN.
- Defined: every transmitted bit SHALL be XORed with the CCSDS pseudo-randomizer, h(x)=x^8+x^7+x^5+x^3+1. The LFSR is seeded to 8'hFF on each handshake and advances with each bit shift. The sequence starts 0xFF,0x48,0x0E,0xC0.
- Undefined: no LFSR logic is present and data_o is the raw frame bit.

Verification
REQ-027 Reset check (CADU_WIDTH=2, CLK_DIV=4): assert rst_i for 3 cycles -> data_o=0, data_valid_o=0, serializer_done_o=0, frame_ready_o=1, fsm_state_o=00.
REQ-028 Single frame, randomizer off, frame 16'h4F00 -> data_o=0100111100000000, each bit held 4 cycles; data_valid_o high 64 cycles; serializer_done_o pulses at handshake+65; frame_ready_o high at handshake+66.
REQ-029 Busy rejection: capture 16'h4F00, then present 16'hFFFF with frame_valid_i pulsed at bit 3 -> output stays 16'h4F00 and 16'hFFFF is not sent.
REQ-030 Back-to-back: frame_valid_i held high, frames 16'hA5C3 then 16'h3C5A -> both serialized MSB first with exactly a 2-cycle data_valid_o gap and two done pulses.
REQ-031 Mid-frame reset: rst_i=1 during bit 5 of 16'h4F00 -> outputs take reset values next cycle, no done pulse; a subsequent 16'h00FF is sent intact.
REQ-032 With CADU_RANDOMIZER_EN defined: frame 16'h4F00 -> serialized 16'hB048; a following frame 16'h0000 -> 16'hFF48 (LFSR reseeded per frame).
